// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, responder state and request record for the data-memory path
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between core and data memory
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane masks, store data replication, load extension and access checks
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        illegal
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v    = 8'(rdata >> {addr_lo, 3'b000});
    half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    illegal   = write ? !(funct3 inside {F3_B, F3_H, F3_W})
                      : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    // size lives in funct3[1:0] for both signed and unsigned forms
    misalign  = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    wmask     = funct3 == F3_B ? 4'b0001 << addr_lo :
                funct3 == F3_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                funct3 == F3_W ? 4'b1111 : 4'b0000;
    wdata_sh  = funct3 == F3_B ? {4{wdata[7:0]}} :
                funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    load_data = funct3 == F3_B  ? {{24{byte_v[7]}}, byte_v} :
                funct3 == F3_H  ? {{16{half_v[15]}}, half_v} :
                funct3 == F3_BU ? {24'h0, byte_v} :
                funct3 == F3_HU ? {16'h0, half_v} : rdata;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated RV32I data memory with sub-word access and error reporting
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t      state;
  req_t        req;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rword, wdata_sh, load_data;
  logic [3:0]  wmask;
  logic        misalign, illegal, oor, err;
  assign rword = mem[req.addr[AW+1:2]];
  assign oor   = {2'b00, req.addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err   = misalign | illegal | oor;
  dmem_lane_align u_align (
    .write     (req.write),
    .funct3    (req.funct3),
    .addr_lo   (req.addr[1:0]),
    .rdata     (rword),
    .wdata     (req.wdata),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .load_data (load_data),
    .misalign  (misalign),
    .illegal   (illegal)
  );
  // storage is not reset; a reset on the ACCESS edge suppresses the commit
  always_ff @(posedge clk)
    if (reset && state == ACCESS && req.write && !err)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[req.addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            req           <= '{write: bus.req_write, funct3: bus.req_funct3, addr: bus.req_addr, wdata: bus.req_wdata};
            cnt           <= 4'(WAIT_STATES);
            bus.req_ready <= 1'b0;
            state         <= WAIT_STATES > 0 ? WAIT : ACCESS;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= cnt == 4'd1 ? ACCESS : WAIT;
        end
        ACCESS: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= err;
          bus.rsp_rdata <= (err || req.write) ? 32'h0 : load_data;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus scoreboard driven checks of dmem_responder
module tb_dmem_responder;
  import mem_pkg::*;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;
  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  rsp_t sb[$];
  vec_t vt[22];
  dmem_responder_if bus ();
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic txn(input vec_t v, input int hold);
    rsp_t r;
    int lat;
    logic [31:0] held;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.w;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.a;
    bus.req_wdata  = v.d;
    bus.rsp_ready  = (hold == 0);
    sb.push_back('{v.er, v.ee});
    for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(WS + 1));
    held = bus.rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, held);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    r = sb.pop_front();
    check("rdata", bus.rsp_rdata, r.rdata);
    check("err", 32'(bus.rsp_err), 32'(r.err));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("ready_back", 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0]  = '{1'b1, F3_W,   32'h10,            32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, F3_W,   32'h10,            32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, F3_B,   32'h13,            32'h00000080, 32'h0,        1'b0};
    vt[3]  = '{1'b0, F3_B,   32'h13,            32'h0,        32'hFFFFFF80, 1'b0};
    vt[4]  = '{1'b0, F3_BU,  32'h13,            32'h0,        32'h00000080, 1'b0};
    vt[5]  = '{1'b0, F3_H,   32'h12,            32'h0,        32'hFFFF80AD, 1'b0};
    vt[6]  = '{1'b0, F3_W,   32'h12,            32'h0,        32'h0,        1'b1};
    vt[7]  = '{1'b1, F3_H,   32'h11,            32'h0000FFFF, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 3'b011, 32'h10,            32'h0,        32'h0,        1'b1};
    vt[9]  = '{1'b0, F3_W,   32'(DEPTH * 4),    32'h0,        32'h0,        1'b1};
    vt[10] = '{1'b1, F3_BU,  32'h10,            32'h000000FF, 32'h0,        1'b1};
    vt[11] = '{1'b1, F3_W,   32'(DEPTH * 4),    32'h11111111, 32'h0,        1'b1};
    vt[12] = '{1'b0, F3_W,   32'h10,            32'h0,        32'h80ADBEEF, 1'b0};
    vt[13] = '{1'b1, F3_W,   32'h14,            32'h00000000, 32'h0,        1'b0};
    vt[14] = '{1'b1, F3_H,   32'h16,            32'h0000A5A5, 32'h0,        1'b0};
    vt[15] = '{1'b0, F3_HU,  32'h16,            32'h0,        32'h0000A5A5, 1'b0};
    vt[16] = '{1'b0, F3_H,   32'h16,            32'h0,        32'hFFFFA5A5, 1'b0};
    vt[17] = '{1'b0, F3_W,   32'h14,            32'h0,        32'hA5A50000, 1'b0};
    vt[18] = '{1'b0, F3_B,   32'h14,            32'h0,        32'h00000000, 1'b0};
    vt[19] = '{1'b0, F3_BU,  32'h17,            32'h0,        32'h000000A5, 1'b0};
    vt[20] = '{1'b1, F3_W,   32'h20,            32'h0BADF00D, 32'h0,        1'b0};
    vt[21] = '{1'b0, F3_W,   32'h10,            32'h0,        32'h80ADBEEF, 1'b0};
    reset          = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    end
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 21; i++) txn(vt[i], 0);
    txn(vt[21], 5);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    txn('{1'b0, F3_W, 32'h20, 32'h0, 32'h0BADF00D, 1'b0}, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the load/store interface. It accepts one load or store request at a time over a valid/ready handshake and models a configurable number of wait states. It performs RV32I sub-word access (byte lanes, sign/zero extension), flags misaligned, illegal and out-of-range accesses, and returns a registered response over a second valid/ready handshake.

## Interface
- DEPTH_WORDS, 1024: memory size in 32-bit words; word index is addr[31:2].
- WAIT_STATES, 1: extra cycles between accept and access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (sampled on clk; low = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request was rejected; no memory side effect.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write/funct3/addr/wdata and load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1→0.
- ACCESS (one cycle):
  - Evaluate errors.
  - If no error: commit the store at the closing edge, or register the extended load data.
  - Go to RESP.
- RESP: rsp_valid=1. Hold rsp_rdata/rsp_err stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE.
- req_ready=0 in WAIT, ACCESS and RESP; request inputs there are ignored.
- Loads:
  - funct3 000 LB: byte at addr[1:0], sign-extended.
  - funct3 001 LH: half at addr[1], sign-extended.
  - funct3 010 LW: full word.
  - funct3 100 LBU: zero-extended byte.
  - funct3 101 LHU: zero-extended half.
- Stores:
  - 000 SB: writes lane addr[1:0] with wdata[7:0].
  - 001 SH: writes lanes {addr[1],0..1} with wdata[15:0].
  - 010 SW: writes all lanes.
  - Other lanes are untouched.
- rsp_err=1, no write, rsp_rdata=0 when any of:
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - funct3 not listed above for that direction;
  - addr[31:2] ≥ DEPTH_WORDS.
- Memory contents are not initialised by reset. Reset affects control state only.

## Timing
- Reset values: state IDLE, req_ready=0 while reset is low, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 the first cycle after reset goes high.
- Latency: accept at edge t0; rsp_valid high from edge t0+WAIT_STATES+1. Errors have identical latency.
- Store commit occurs at the edge leaving ACCESS, which is the same edge that raises rsp_valid.
- The next request can be accepted no earlier than one cycle after the response handshake. Minimum period per transaction is WAIT_STATES+3 cycles with rsp_ready held high.
- rsp_valid, once high, stays high and rsp_rdata/rsp_err stay stable until handshake; back-pressure has no limit.
- Reset low in any state: return to IDLE next edge, drop the pending request, and clear the response outputs. A store interrupted before its ACCESS edge is never written.
- WAIT_STATES=0: IDLE→ACCESS directly; latency is 1.

## Structure
- Shared package mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - a request struct {write, funct3, addr, wdata}.
- The core's controller reuses the mem_pkg funct3 constants.
- Sub-module dmem_lane_align is combinational. From funct3, addr[1:0] and the read word it produces:
  - the 4-bit byte write mask;
  - the lane-shifted write data;
  - the extended load result;
  - the misalign/illegal flags.
- The top holds the FSM, counter, request latch, storage array and response registers.

## Test plan
- Reset low for 2 cycles with req_valid=1 → no accept, rsp_valid=0; after release req_ready=1.
- SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_STATES=1 → each rsp_valid rises 2 edges after accept; load returns 0xDEADBEEF, rsp_err=0.
- SB 0x80 @0x13 over that word, then LB/LBU @0x13 and LH @0x12 → 0xFFFFFF80, 0x00000080, 0xFFFF80AD.
- LW @0x12, SH @0x11, funct3=011 load, and LW @ (DEPTH_WORDS*4):
  - each → rsp_err=1, rsp_rdata=0;
  - read-back of 0x10 is unchanged.
- rsp_ready held low 5 cycles → rsp_valid, rsp_rdata stable and req_ready=0 throughout; transaction completes on release.
- SW @0x20 with reset pulsed low during WAIT → no response. A subsequent LW @0x20 returns the prior contents.
